// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and widths.
// Imported by the decoder and the execute-stage ALU.
package alu_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;
   localparam logic [2:0] ALU_SLL = 3'd5;
   localparam logic [2:0] ALU_SRL = 3'd6;
   localparam logic [2:0] ALU_SRA = 3'd7;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for SLL/SRL/SRA.
// Modes other than SRL/SRA fall through to SLL.
module alu_shifter
   import alu_pkg::*;
(
   input  logic [XLEN-1:0] a,
   input  logic [4:0]      shamt,
   input  logic [2:0]      mode,
   output logic [XLEN-1:0] res
);

   always_comb begin
      res = a << shamt;
      unique case (1'b1)
         (mode == ALU_SRL): res = a >> shamt;
         (mode == ALU_SRA): res = $unsigned($signed(a) >>> shamt);
         default:           res = a << shamt;
      endcase
   end

endmodule

// File: rtl/rv32i_alu.sv
// RV32I execute-stage ALU with a one-cycle registered result.
// zero is computed from the same next value so it tracks out exactly.
module rv32i_alu
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [2:0]      op,
   output logic [XLEN-1:0] out,
   output logic            zero
);

   logic            sub;
   logic [XLEN-1:0] bx;
   logic [XLEN-1:0] cin;
   logic [XLEN-1:0] sum;
   logic [XLEN-1:0] shres;
   logic [XLEN-1:0] nxt;

   // One adder serves both: SUB is a + ~b + 1.
   assign sub = (op == ALU_SUB);
   assign bx  = sub ? ~b : b;
   assign cin = {{(XLEN-1){1'b0}}, sub};
   assign sum = a + bx + cin;

   alu_shifter u_shifter (
      .a     (a),
      .shamt (b[4:0]),
      .mode  (op),
      .res   (shres)
   );

   always_comb begin
      nxt = sum;
      unique case (1'b1)
         (op == ALU_ADD),
         (op == ALU_SUB): nxt = sum;
         (op == ALU_AND): nxt = a & b;
         (op == ALU_OR):  nxt = a | b;
         (op == ALU_XOR): nxt = a ^ b;
         default:         nxt = shres;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out  <= '0;
         zero <= 1'b1;
      end else begin
         out  <= nxt;
         zero <= (nxt == '0);
      end
   end

endmodule

// File: tb/tb_rv32i_alu.sv
// Directed-vector bench for rv32i_alu.
// Drives on negedge, samples on the following negedge.
module tb_rv32i_alu;
   import alu_pkg::*;

   logic        clk;
   logic        rst;
   logic [31:0] a;
   logic [31:0] b;
   logic [2:0]  op;
   logic [31:0] out;
   logic        zero;

   int npass;
   int ntot;

   rv32i_alu dut (
      .clk  (clk),
      .rst  (rst),
      .a    (a),
      .b    (b),
      .op   (op),
      .out  (out),
      .zero (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      ntot++;
      if (got === exp) npass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Apply one vector, wait one cycle, check out and optionally zero.
   task automatic vec(input string tag,
                      input logic [31:0] va,
                      input logic [31:0] vb,
                      input logic [2:0]  vop,
                      input logic [31:0] eout,
                      input logic        czero,
                      input logic        ezero);
      @(negedge clk);
      rst = 1'b0;
      a   = va;
      b   = vb;
      op  = vop;
      @(negedge clk);
      check(tag, out, eout);
      if (czero) check({tag, "_z"}, {31'b0, zero}, {31'b0, ezero});
   endtask

   logic [31:0] eo;
   logic [31:0] k;

   initial begin
      npass = 0;
      ntot  = 0;
      rst   = 1'b1;
      a     = 32'd5;
      b     = 32'd3;
      op    = ALU_ADD;

      @(negedge clk);
      @(negedge clk);
      check("rst_out", out, 32'h0);
      check("rst_zero", {31'b0, zero}, 32'd1);

      rst = 1'b0;
      @(negedge clk);
      check("post_rst_out", out, 32'd8);
      check("post_rst_zero", {31'b0, zero}, 32'd0);

      vec("add_wrap", 32'hFFFFFFFF, 32'd1, ALU_ADD, 32'h0, 1'b1, 1'b1);
      vec("sub_wrap", 32'h0, 32'd1, ALU_SUB, 32'hFFFFFFFF, 1'b1, 1'b0);
      vec("sub_eq", 32'd7, 32'd7, ALU_SUB, 32'h0, 1'b1, 1'b1);
      vec("and", 32'hF0F0_1234, 32'h0FF0_FF00, ALU_AND,
          32'h00F0_1200, 1'b1, 1'b0);
      vec("or", 32'hF0F0_1234, 32'h0FF0_FF00, ALU_OR,
          32'hFFF0_FF34, 1'b0, 1'b0);
      vec("xor", 32'hF0F0_1234, 32'h0FF0_FF00, ALU_XOR,
          32'hFF00_ED34, 1'b0, 1'b0);
      vec("sll", 32'h8000_0001, 32'd4, ALU_SLL, 32'h0000_0010, 1'b0, 1'b0);
      vec("srl", 32'h8000_0001, 32'd4, ALU_SRL, 32'h0800_0000, 1'b0, 1'b0);
      vec("sra", 32'h8000_0001, 32'd4, ALU_SRA, 32'hF800_0000, 1'b0, 1'b0);
      vec("sra_sh0", 32'h8000_0001, 32'h20, ALU_SRA,
          32'h8000_0001, 1'b1, 1'b0);
      vec("sll_31", 32'h0000_0003, 32'hFFFF_FFFF, ALU_SLL,
          32'h8000_0000, 1'b0, 1'b0);
      vec("srl_31", 32'h8000_0000, 32'd31, ALU_SRL, 32'h1, 1'b0, 1'b0);
      vec("sra_pos", 32'h7000_0000, 32'd4, ALU_SRA,
          32'h0700_0000, 1'b0, 1'b0);

      // Reset mid-stream discards the in-flight result.
      @(negedge clk);
      a   = 32'd9;
      b   = 32'd1;
      op  = ALU_ADD;
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_out", out, 32'h0);
      check("mid_rst_zero", {31'b0, zero}, 32'd1);
      rst = 1'b0;

      // Streaming ramp: a = b = k, op steps every 1000 cycles.
      for (int i = 0; i <= 5000; i++) begin
         @(negedge clk);
         if (i > 0) begin
            k = 32'(i - 1);
            case ((i - 1) / 1000)
               0:       eo = k << 1;
               1:       eo = 32'h0;
               2:       eo = k;
               3:       eo = k;
               default: eo = 32'h0;
            endcase
            check("ramp_out", out, eo);
            check("ramp_zero", {31'b0, zero}, {31'b0, (out == 32'h0)});
         end
         if (i < 5000) begin
            a  = 32'(i);
            b  = 32'(i);
            op = 3'(i / 1000);
         end
      end

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/rv32i_alu.md
# rv32i_alu

32-bit integer ALU for the RV32I core's execute stage. Computes add, sub, and, or, xor and the three shifts on two 32-bit operands selected by a 3-bit opcode. The result is registered, giving a one-cycle latency. The registered result feeds the writeback mux; the decoder drives the operands and opcode.

## Interface
- Parameters: none. Data width is fixed at 32.
- Clocking: one clock; reset is synchronous and active-high.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- a  input  32  operand A.
- b  input  32  operand B; bits [4:0] are the shift amount for shift ops.
- op  input  3  operation select.
- out  output  32  registered result.
- zero  output  1  registered; 1 when the registered result equals 0.

## Operation
Opcode encoding:
- 0: ADD, a + b modulo 2^32; carry discarded.
- 1: SUB, a − b modulo 2^32; borrow discarded; two's-complement wrap.
- 2: AND, a & b.
- 3: OR, a | b.
- 4: XOR, a ^ b.
- 5: SLL, a << b[4:0].
- 6: SRL, a >> b[4:0], zero fill.
- 7: SRA, a >>> b[4:0], sign fill from a[31].

Rules:
- b[31:5] are ignored for shifts; a shift amount of 0 returns a unchanged.
- No overflow or carry outputs. Signedness matters only for SRA.
- A combinational next-result is computed from a, b and op; out and zero latch it each cycle.

## Timing
- Latency is one cycle: inputs sampled at edge N appear on out/zero after edge N.
- Inputs may change every cycle; full throughput; no handshake and no stall.
- Reset: when rst=1 at a rising edge, out ← 0 and zero ← 1, regardless of op, a or b. Reset has priority over any computation.
- First edge with rst=0 loads the computed result.
- Reset asserted mid-stream discards the in-flight result; there is no other state.
- Before the first clock edge, outputs are undefined.
- zero always reflects the value currently held in out; it is never one cycle behind it.

## Structure
- Shared package alu_pkg:
  - localparams ALU_ADD=3'd0, ALU_SUB=3'd1, ALU_AND=3'd2, ALU_OR=3'd3, ALU_XOR=3'd4, ALU_SLL=3'd5, ALU_SRL=3'd6, ALU_SRA=3'd7;
  - XLEN=32.
  - The decoder imports the same package.
- One sub-module is natural: alu_shifter. It is combinational, takes a, shamt[4:0] and mode (SLL/SRL/SRA), and returns a 32-bit result.
- The top holds:
  - the add/sub path, with one adder and b inverted plus carry-in for SUB;
  - the logic ops;
  - the result mux;
  - the output register.

## Test plan
- Reset: rst=1 with a=5, b=3, op=ADD → after the edge out=0, zero=1. Release rst → the next edge gives out=8, zero=0.
- Add/sub wrap:
  - ADD a=32'hFFFFFFFF, b=1 → out=0, zero=1.
  - SUB a=0, b=1 → out=32'hFFFFFFFF.
  - SUB a=7, b=7 → zero=1.
- Logic: a=32'hF0F0_1234, b=32'h0FF0_FF00:
  - AND → 32'h00F0_1200;
  - OR → 32'hFFF0_FF34;
  - XOR → 32'hFF00_ED34.
- Shifts: a=32'h8000_0001:
  - SLL b=4 → 32'h0000_0010;
  - SRL b=4 → 32'h0800_0000;
  - SRA b=4 → 32'hF800_0000;
  - SRA b=32'h0000_0020, shamt=0 → 32'h8000_0001.
- Streaming ramp:
  - Hold op, incrementing a and b by 1 each cycle from 0, stepping op 0→4 every 1000 cycles.
  - Each out must equal the reference model of the prior cycle's inputs, e.g. ADD gives 2k and SUB gives 0 throughout.
  - Check zero against out every cycle.
